// File: rtl/cmp_bus_p_if.sv
// rtl/cmp_bus_p_if.sv - opcode and status bundle between the transport controller and the compare unit
interface cmp_bus_p_if #(
    parameter int NPRED = 4
) ();
    logic [3:0]       op_sel;
    logic             cmp_true;
    logic [NPRED-1:0] pred;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output op_sel,
        input  cmp_true, pred, busy, done, err
    );

    modport slave (
        input  op_sel,
        output cmp_true, pred, busy, done, err
    );
endinterface

// File: rtl/cmp_bus_p.sv
// rtl/cmp_bus_p.sv - bus-attached compare unit retiring results into a small predicate file
module cmp_bus_p #(
    parameter int WIDTH = 24,
    parameter int NPRED = 4,
    parameter int PIPE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bus,
    cmp_bus_p_if.slave       cif
);
    localparam int PW = $clog2(NPRED);

    localparam logic [3:0] OP_IDLE     = 4'd0;
    localparam logic [3:0] OP_WR_A     = 4'd1;
    localparam logic [3:0] OP_TRIG     = 4'd2;
    localparam logic [3:0] OP_WR_TYPE  = 4'd3;
    localparam logic [3:0] OP_RD_RES   = 4'd4;
    localparam logic [3:0] OP_RD_PRED  = 4'd5;
    localparam logic [3:0] OP_CLR_PRED = 4'd6;

    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [2:0]       cond_q, cond_d;
    logic             sgn_q, sgn_d;
    logic [PW-1:0]    dest_q, dest_d;
    logic             result_q, result_d;
    logic [NPRED-1:0] pred_q, pred_d;
    logic             cmp_true_q, cmp_true_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Stage register: operands and type snapshot taken at launch (opb_q doubles as stage B)
    logic             s_v_q, s_v_d;
    logic [WIDTH-1:0] s_a_q, s_a_d;
    logic [2:0]       s_cond_q, s_cond_d;
    logic             s_sgn_q, s_sgn_d;
    logic [PW-1:0]    s_dest_q, s_dest_d;

    logic             ret_v, ret_r;
    logic [PW-1:0]    ret_dest;
    logic             drv_en;
    logic [WIDTH-1:0] drv_val;

    function automatic logic cmp_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic [2:0] cond, input logic sgn);
        logic eq, gt, z;
        eq = (a == b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        z  = (a == '0);
        case (cond)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd2:    return gt;
            3'd3:    return gt || eq;
            3'd4:    return z;
            3'd5:    return !z;
            3'd6:    return !gt && !eq;
            default: return !gt;
        endcase
    endfunction

    always_comb begin
        opa_d      = opa_q;
        opb_d      = opb_q;
        cond_d     = cond_q;
        sgn_d      = sgn_q;
        dest_d     = dest_q;
        result_d   = result_q;
        pred_d     = pred_q;
        cmp_true_d = cmp_true_q;
        done_d     = 1'b0;
        err_d      = err_q;
        s_v_d      = 1'b0;
        s_a_d      = s_a_q;
        s_cond_d   = s_cond_q;
        s_sgn_d    = s_sgn_q;
        s_dest_d   = s_dest_q;

        case (cif.op_sel)
            OP_IDLE, OP_RD_RES, OP_RD_PRED: ;
            OP_WR_A:     opa_d = bus;
            OP_TRIG: begin
                opb_d    = bus;
                s_v_d    = (PIPE != 0);
                s_a_d    = opa_q;
                s_cond_d = cond_q;
                s_sgn_d  = sgn_q;
                s_dest_d = dest_q;
            end
            OP_WR_TYPE: begin
                cond_d = bus[2:0];
                sgn_d  = bus[3];
                dest_d = bus[4 +: PW];
            end
            OP_CLR_PRED: pred_d = '0;
            default:     err_d = 1'b1;
        endcase

        if (PIPE != 0) begin
            ret_v    = s_v_q;
            ret_r    = cmp_eval(s_a_q, opb_q, s_cond_q, s_sgn_q);
            ret_dest = s_dest_q;
        end else begin
            ret_v    = (cif.op_sel == OP_TRIG);
            ret_r    = cmp_eval(opa_q, bus, cond_q, sgn_q);
            ret_dest = dest_q;
        end

        // Retire after the clear so a same-edge CLR_PRED keeps only the new bit
        if (ret_v) begin
            pred_d[ret_dest] = ret_r;
            result_d         = ret_r;
            cmp_true_d       = ret_r;
            done_d           = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q      <= '0;
            opb_q      <= '0;
            cond_q     <= '0;
            sgn_q      <= 1'b0;
            dest_q     <= '0;
            result_q   <= 1'b0;
            pred_q     <= '0;
            cmp_true_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            s_v_q      <= 1'b0;
            s_a_q      <= '0;
            s_cond_q   <= '0;
            s_sgn_q    <= 1'b0;
            s_dest_q   <= '0;
        end else begin
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cond_q     <= cond_d;
            sgn_q      <= sgn_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            pred_q     <= pred_d;
            cmp_true_q <= cmp_true_d;
            done_q     <= done_d;
            err_q      <= err_d;
            s_v_q      <= s_v_d;
            s_a_q      <= s_a_d;
            s_cond_q   <= s_cond_d;
            s_sgn_q    <= s_sgn_d;
            s_dest_q   <= s_dest_d;
        end
    end

    always_comb begin
        drv_en  = 1'b0;
        drv_val = '0;
        if (!rst) begin
            if (cif.op_sel == OP_RD_RES) begin
                drv_en  = 1'b1;
                drv_val = WIDTH'(result_q);
            end else if (cif.op_sel == OP_RD_PRED) begin
                drv_en  = 1'b1;
                drv_val = WIDTH'(pred_q);
            end
        end
    end

    assign bus = drv_en ? drv_val : {WIDTH{1'bz}};

    assign cif.cmp_true = cmp_true_q;
    assign cif.pred     = pred_q;
    assign cif.busy     = (PIPE != 0) && s_v_q;
    assign cif.done     = done_q;
    assign cif.err      = err_q;
endmodule

// File: tb/tb_cmp_bus_p.sv
// tb/tb_cmp_bus_p.sv - bench driving single-stage and pipelined compare units side by side
module tb_cmp_bus_p;
    localparam int W  = 24;
    localparam int NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] tb_data = '0;
    logic         tb_en;
    wire  [W-1:0] bus0, bus1;

    assign tb_en = rst || !(op == 4'd4 || op == 4'd5);
    assign bus0  = tb_en ? tb_data : {W{1'bz}};
    assign bus1  = tb_en ? tb_data : {W{1'bz}};

    cmp_bus_p_if #(.NPRED(NP)) if0 ();
    cmp_bus_p_if #(.NPRED(NP)) if1 ();
    assign if0.op_sel = op;
    assign if1.op_sel = op;

    cmp_bus_p #(.WIDTH(W), .NPRED(NP), .PIPE(0)) u0 (.clk(clk), .rst(rst), .bus(bus0), .cif(if0.slave));
    cmp_bus_p #(.WIDTH(W), .NPRED(NP), .PIPE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1), .cif(if1.slave));

    logic [7:0]   obs  [2];
    logic [W-1:0] bobs [2];
    assign obs[0]  = {if0.cmp_true, if0.pred, if0.busy, if0.done, if0.err};
    assign obs[1]  = {if1.cmp_true, if1.pred, if1.busy, if1.done, if1.err};
    assign bobs[0] = bus0;
    assign bobs[1] = bus1;

    // Reference state: index 0 retires immediately, index 1 holds one pending compare
    longint m_opa  [2];
    int     m_type [2];
    int     m_pred [2];
    int     m_res  [2];
    bit     m_cmp  [2];
    bit     m_done [2];
    bit     m_err  [2];
    bit     p_v;
    bit     p_r;
    int     p_d;

    int vec  = 0;
    int miss = 0;

    function automatic longint sx(input longint v);
        longint half;
        half = longint'(1) << (W - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    function automatic bit ref_cmp(input longint a, input longint b, input int ty);
        longint x, y;
        x = a;
        y = b;
        if ((ty / 8) % 2 == 1) begin
            x = sx(a);
            y = sx(b);
        end
        case (ty % 8)
            0:       return a == b;
            1:       return a != b;
            2:       return x > y;
            3:       return x >= y;
            4:       return a == 0;
            5:       return a != 0;
            6:       return x < y;
            default: return x <= y;
        endcase
    endfunction

    function automatic logic [7:0] exp_obs(input int k);
        return {m_cmp[k], 4'(m_pred[k]), (k == 1) ? p_v : 1'b0, m_done[k], m_err[k]};
    endfunction

    function automatic logic [W-1:0] exp_bus(input int k);
        if (!rst && op == 4'd4) return W'(m_res[k]);
        if (!rst && op == 4'd5) return W'(m_pred[k]);
        return tb_data;
    endfunction

    task automatic model_update();
        bit rv, rr;
        int rd;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_opa[k] = 0; m_type[k] = 0; m_pred[k] = 0; m_res[k] = 0;
                m_cmp[k] = 0; m_done[k] = 0; m_err[k] = 0;
                if (k == 1) p_v = 0;
            end else begin
                rv = 0; rr = 0; rd = 0;
                if (k == 0 && op == 4'd2) begin
                    rv = 1;
                    rr = ref_cmp(m_opa[0], longint'(tb_data), m_type[0]);
                    rd = (m_type[0] / 16) % NP;
                end
                if (k == 1) begin
                    if (p_v) begin
                        rv = 1; rr = p_r; rd = p_d;
                    end
                    p_v = (op == 4'd2);
                    if (op == 4'd2) begin
                        p_r = ref_cmp(m_opa[1], longint'(tb_data), m_type[1]);
                        p_d = (m_type[1] / 16) % NP;
                    end
                end
                if (op == 4'd6) m_pred[k] = 0;
                if (rv) begin
                    if (rr) m_pred[k] = m_pred[k] | (1 << rd);
                    else    m_pred[k] = m_pred[k] & ~(1 << rd);
                    m_res[k] = int'(rr);
                    m_cmp[k] = rr;
                end
                m_done[k] = rv;
                if (op == 4'd1) m_opa[k] = longint'(tb_data);
                if (op == 4'd3) m_type[k] = int'(tb_data[6:0]);
                if (op >= 4'd7) m_err[k] = 1;
            end
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [W-1:0] d);
        op      = o;
        tb_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd0, W'($urandom));
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (obs[k] !== 8'h00) begin
                miss++;
                $display("FAIL reset_status dut%0d: got %b expected 00000000", k, obs[k]);
            end
        end
        rst = 1'b0;
        drive(4'd5, W'($urandom));
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (bobs[k] !== '0) begin
                miss++;
                $display("FAIL reset_rd_pred dut%0d: got %h expected 000000", k, bobs[k]);
            end
        end
        tick();
    endtask

    task automatic test_gt_signed();
        logic [3:0]   ops [6] = '{4'd1, 4'd3, 4'd2, 4'd0, 4'd3, 4'd2};
        logic [W-1:0] dat [6] = '{24'hFFFFFF, 24'h02, 24'h000001, 24'h0, 24'h0A, 24'h000001};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], dat[i]);
            tick();
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (obs[k] !== exp_obs(k)) begin
                    miss++;
                    $display("FAIL gt_status dut%0d step%0d: got %b expected %b", k, i, obs[k], exp_obs(k));
                end
            end
            if (i == 2) begin
                vec++;
                if ({if0.done, if0.cmp_true} !== 2'b11) begin
                    miss++;
                    $display("FAIL gt_unsigned_u0: got done/r %b expected 11", {if0.done, if0.cmp_true});
                end
            end
            if (i == 3) begin
                vec++;
                if ({if1.done, if1.cmp_true} !== 2'b11) begin
                    miss++;
                    $display("FAIL gt_unsigned_u1: got done/r %b expected 11", {if1.done, if1.cmp_true});
                end
            end
            if (i == 5) begin
                vec++;
                if ({if0.done, if0.cmp_true} !== 2'b10) begin
                    miss++;
                    $display("FAIL gt_signed_u0: got done/r %b expected 10", {if0.done, if0.cmp_true});
                end
            end
        end
        drive(4'd0, '0);
        tick();
        vec++;
        if ({if1.done, if1.cmp_true} !== 2'b10) begin
            miss++;
            $display("FAIL gt_signed_u1: got done/r %b expected 10", {if1.done, if1.cmp_true});
        end
    endtask

    task automatic test_zero_dest();
        logic [3:0]   ops [7] = '{4'd3, 4'd1, 4'd2, 4'd0, 4'd5, 4'd6, 4'd5};
        logic [W-1:0] dat [7] = '{24'h34, 24'h0, 24'h123, 24'h0, 24'h0, 24'h0, 24'h0};
        logic [W-1:0] want;
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], dat[i]);
            if (i == 4 || i == 6) begin
                want = (i == 4) ? 24'h8 : 24'h0;
                for (int k = 0; k < 2; k++) begin
                    vec++;
                    if (bobs[k] !== want) begin
                        miss++;
                        $display("FAIL zdest_rd_pred dut%0d step%0d: got %h expected %h", k, i, bobs[k], want);
                    end
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (obs[k] !== exp_obs(k)) begin
                    miss++;
                    $display("FAIL zdest_status dut%0d step%0d: got %b expected %b", k, i, obs[k], exp_obs(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops [8] = '{4'd3, 4'd1, 4'd2, 4'd2, 4'd0, 4'd3, 4'd2, 4'd0};
        logic [W-1:0] dat [8] = '{24'h00, 24'h5, 24'h5, 24'h5, 24'h0, 24'h11, 24'h5, 24'h0};
        logic [1:0]   bd  [8] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], dat[i]);
            tick();
            vec++;
            if ({if1.busy, if1.done} !== bd[i]) begin
                miss++;
                $display("FAIL b2b_busy_done step%0d: got %b expected %b", i, {if1.busy, if1.done}, bd[i]);
            end
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (obs[k] !== exp_obs(k)) begin
                    miss++;
                    $display("FAIL b2b_status dut%0d step%0d: got %b expected %b", k, i, obs[k], exp_obs(k));
                end
            end
        end
        drive(4'd5, '0);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (bobs[k] !== 24'h1) begin
                miss++;
                $display("FAIL b2b_rd_pred dut%0d: got %h expected 000001", k, bobs[k]);
            end
        end
        tick();
    endtask

    task automatic test_rst_midflight();
        logic [3:0]   ops [9] = '{4'd6, 4'd3, 4'd1, 4'd2, 4'd0, 4'd3, 4'd1, 4'd2, 4'd6};
        logic [W-1:0] dat [9] = '{24'h0, 24'h20, 24'h7, 24'h7, 24'h0, 24'h20, 24'h9, 24'h9, 24'h0};
        logic         rs  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rst = rs[i];
            drive(ops[i], dat[i]);
            tick();
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (obs[k] !== exp_obs(k)) begin
                    miss++;
                    $display("FAIL rstmid_status dut%0d step%0d: got %b expected %b", k, i, obs[k], exp_obs(k));
                end
            end
            if (i == 4) begin
                vec++;
                if ({if1.done, if1.busy, if1.pred} !== 6'b0) begin
                    miss++;
                    $display("FAIL rstmid_discard: got done/busy/pred %b expected 000000", {if1.done, if1.busy, if1.pred});
                end
            end
            if (i == 8) begin
                vec++;
                if ({if1.done, if1.pred} !== 5'b10100) begin
                    miss++;
                    $display("FAIL clr_on_retire: got done/pred %b expected 10100", {if1.done, if1.pred});
                end
            end
        end
        rst = 1'b0;
        drive(4'd4, '0);
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (bobs[k] !== exp_bus(k)) begin
                miss++;
                $display("FAIL rstmid_rd_res dut%0d: got %h expected %h", k, bobs[k], exp_bus(k));
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [3:0]   ops [6] = '{4'd9, 4'd1, 4'd3, 4'd2, 4'd5, 4'd0};
        logic [W-1:0] dat [6] = '{24'h0, 24'h3, 24'h01, 24'h4, 24'h0, 24'h0};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], dat[i]);
            tick();
            vec++;
            if ({if0.err, if1.err} !== 2'b11) begin
                miss++;
                $display("FAIL illegal_sticky step%0d: got %b expected 11", i, {if0.err, if1.err});
            end
        end
        rst = 1'b1;
        drive(4'd0, '0);
        tick();
        rst = 1'b0;
        vec++;
        if ({if0.err, if1.err} !== 2'b00) begin
            miss++;
            $display("FAIL illegal_rst_clear: got %b expected 00", {if0.err, if1.err});
        end
    endtask

    task automatic test_random();
        logic [3:0]   o;
        logic [W-1:0] d;
        int           pick;
        for (int i = 0; i < 500; i++) begin
            pick = $urandom_range(0, 99);
            rst  = (pick < 3);
            o = (pick < 90) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
            if (rst && (o == 4'd4 || o == 4'd5)) o = 4'd0;
            case ($urandom_range(0, 4))
                0:       d = W'(m_opa[0]);
                1:       d = '0;
                2:       d = 24'h800000 | W'($urandom_range(0, 3));
                default: d = W'($urandom);
            endcase
            if (o == 4'd3) d = W'($urandom_range(0, 127));
            drive(o, d);
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (bobs[k] !== exp_bus(k)) begin
                    miss++;
                    $display("FAIL rand_bus dut%0d iter%0d op%0d: got %h expected %h", k, i, o, bobs[k], exp_bus(k));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (obs[k] !== exp_obs(k)) begin
                    miss++;
                    $display("FAIL rand_status dut%0d iter%0d op%0d: got %b expected %b", k, i, o, obs[k], exp_obs(k));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gt_signed();
        test_zero_dest();
        test_back_to_back();
        test_rst_midflight();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/cmp_bus_p.md
# cmp_bus_p

Parametrised bus-attached compare unit for the transport-triggered datapath. It captures operands from the shared tri-state bus and fires a compare when operand B is written. Results are retired into a small predicate file that drives control flow. It adds signed compares, selectable predicate destinations, an optional pipeline stage, a completion pulse and a sticky illegal-op flag.

## Interface
- WIDTH, 24, operand/bus width in bits (≥8)
- NPRED, 4, predicate register count (power of two, 2–8)
- PIPE, 0, 0 = single-stage compare; 1 = extra operand register stage
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- op_sel  input  4  transport opcode for this cycle
- bus  inout  WIDTH  shared data bus; driven only on read opcodes, else high-Z
- cmp_true  output  1  result bit of most recently retired compare
- pred  output  NPRED  predicate file contents
- busy  output  1  compare in flight (PIPE=1 only; tied 0 when PIPE=0)
- done  output  1  one-cycle pulse on the edge a compare retires
- err  output  1  sticky: illegal opcode seen

## Operation
- op_sel decode, sampled each rising edge:
  - 0 idle
  - 1 WR_A: opa ← bus
  - 2 TRIG: opb ← bus, launch compare with current type
  - 3 WR_TYPE: type ← bus[6:0]
  - 4 RD_RES: bus ← result, zero-extended
  - 5 RD_PRED: bus ← pred, zero-extended
  - 6 CLR_PRED: pred ← 0
  - 7–15 no action; err ← 1
- type fields:
  - [2:0] cond: e=0, ne=1, g=2, ge=3, z=4, nz=5, l=6, le=7
  - [3] signed: g/ge/l/le use two's complement, otherwise no effect
  - [6:4] dest: predicate index; low clog2(NPRED) bits used, upper ignored
- z/nz test opa only; opb is ignored for these.
- TRIG compares using opa and the bus value present on that cycle.
- type and dest are latched with the launch. A later WR_TYPE does not affect an in-flight compare.
- Retire writes:
  - result ← {0…, r}
  - pred[dest] ← r
  - cmp_true ← r
  - done pulses for one cycle
- Bus drive is combinational from op_sel and is suppressed (high-Z) while rst = 1.

## Timing
- Reset values: opa, opb, result, pred, err, done, busy, cmp_true = 0; type = 0 (e, unsigned, dest 0); pipeline valid = 0.
- PIPE=0: result, pred and done update on the same edge that samples TRIG (latency 1); busy is always 0.
- PIPE=1:
  - TRIG edge loads the stage register and sets busy; the next edge retires (latency 2).
  - Back-to-back TRIGs give throughput of 1 per cycle; busy stays high continuously.
- RD_RES / RD_PRED while busy return the previous retired values; there is no stall.
- CLR_PRED on the same edge as a retire: pred[dest] ← r and all other bits ← 0.
- WR_A on the cycle after TRIG (PIPE=1) does not disturb the in-flight compare.
- rst asserted mid-flight discards the compare: no done, and pred/result are cleared.
- err clears only on rst.

## Test plan
- Reset then RD_PRED: bus = 0, busy = 0, done = 0, err = 0.
- WIDTH=24, WR_A 0xFFFFFF, WR_TYPE 0x02 (g unsigned), TRIG 0x000001 -> r = 1, done pulses. Repeat with WR_TYPE 0x0A (signed) -> r = 0, cmp_true = 0.
- WR_TYPE 0x34 (z, dest 3), WR_A 0, TRIG 0x123 -> pred = 4'b1000. Then CLR_PRED -> pred = 0.
- PIPE=1: TRIGs on consecutive cycles (A=5; B=5 with e; then ne dest 1) -> busy high 2 cycles, done on 2 consecutive edges, pred = 4'b0001.
- PIPE=1: TRIG, then rst on the next edge -> no done, pred = 0, result = 0. Also CLR_PRED on the retire edge with dest 2 and r = 1 -> pred = 4'b0100.
- op_sel = 9 -> err = 1 and stays 1 through subsequent valid ops until rst. Bus is high-Z on all non-read cycles.
